// File: rtl/stack_alu_sequencer_if.sv
// Command channel of the stack ALU sequencer: valid/ready handshake carrying
// an opcode and a PUSH immediate, plus the one-cycle completion pulses.
interface stack_alu_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             done;
    logic             err;

    // Command source side.
    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready,
        input  done,
        input  err
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready,
        output done,
        output err
    );
endinterface

// File: rtl/stack_alu_sequencer.sv
// Evaluation-stack engine around the external 8-bit ALU. Each command runs
// IDLE -> EXEC (drive ALU, capture result, check legality) -> WB (commit),
// and done/err pulses in the following IDLE cycle.
module stack_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int PTR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    stack_alu_sequencer_if.slave cmd,
    output logic [1:0]           alu_control,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    input  logic [WIDTH-1:0]     alu_out,
    input  logic                 alu_zero,
    output logic [WIDTH-1:0]     tos,
    output logic [PTR_W:0]       depth,
    output logic                 empty,
    output logic                 full,
    output logic                 zero_flag
);

    localparam int DEPTH = 2 ** PTR_W;

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_POP   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_AND   = 3'd4,
        OP_DUP   = 3'd5,
        OP_SWAP  = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    state_t           r_state;
    state_t           w_next_state;
    logic [PTR_W:0]   r_sp;
    logic [WIDTH-1:0] r_stack [DEPTH];
    op_t              r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_result;
    logic             r_res_zero;
    logic             r_legal;
    logic             r_zero_flag;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_legal;
    logic             w_is_empty;
    logic             w_is_full;
    logic             w_has_two;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_nos_idx;
    logic [PTR_W-1:0] w_push_idx;

    // Stack pointer decode: sp counts entries, so TOS lives at sp-1 and NOS at sp-2.
    assign w_push_idx = r_sp[PTR_W-1:0];
    assign w_top_idx  = r_sp[PTR_W-1:0] - PTR_W'(1);
    assign w_nos_idx  = r_sp[PTR_W-1:0] - PTR_W'(2);
    assign w_is_empty = (r_sp == '0);
    assign w_is_full  = (r_sp == (PTR_W+1)'(DEPTH));
    assign w_has_two  = (r_sp >= (PTR_W+1)'(2));
    assign w_accept   = cmd.cmd_valid && (r_state == S_IDLE);

    assign tos        = w_is_empty ? '0 : r_stack[w_top_idx];
    assign depth      = r_sp;
    assign empty      = w_is_empty;
    assign full       = w_is_full;
    assign zero_flag  = r_zero_flag;
    assign cmd.done   = r_done;
    assign cmd.err    = r_err;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            r_state <= w_next_state;
        end
    end

    // Next-state: one command walks IDLE -> EXEC -> WB -> IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (cmd.cmd_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: handshake ready and ALU drive, active only during EXEC.
    always_comb begin
        cmd.cmd_ready = (r_state == S_IDLE);
        alu_control   = ALU_ADD;
        alu_a         = '0;
        alu_b         = '0;
        if (r_state == S_EXEC) begin
            case (r_op)
                OP_PUSH: begin
                    alu_control = ALU_PASS;
                    alu_b       = r_data;
                end
                OP_DUP: begin
                    alu_control = ALU_PASS;
                    alu_b       = tos;
                end
                OP_ADD, OP_SUB, OP_AND: begin
                    alu_control = (r_op == OP_ADD) ? ALU_ADD :
                                  (r_op == OP_SUB) ? ALU_SUB : ALU_AND;
                    alu_a       = r_stack[w_nos_idx];
                    alu_b       = tos;
                end
                default: ;
            endcase
        end
    end

    // Legality of the latched command against the current stack occupancy.
    always_comb begin
        w_legal = 1'b1;
        case (r_op)
            OP_PUSH:                         w_legal = !w_is_full;
            OP_DUP:                          w_legal = !w_is_full && !w_is_empty;
            OP_POP:                          w_legal = !w_is_empty;
            OP_ADD, OP_SUB, OP_AND, OP_SWAP: w_legal = w_has_two;
            default:                         w_legal = 1'b1;
        endcase
    end

    // Control path: latch command, capture ALU result, commit sp/zero flag in WB.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= OP_PUSH;
            r_data      <= '0;
            r_result    <= '0;
            r_res_zero  <= 1'b0;
            r_legal     <= 1'b0;
            r_sp        <= '0;
            r_zero_flag <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_accept) begin
                r_op   <= op_t'(cmd.cmd_op);
                r_data <= cmd.cmd_data;
            end
            if (r_state == S_EXEC) begin
                r_result   <= alu_out;
                r_res_zero <= alu_zero;
                r_legal    <= w_legal;
            end
            if (r_state == S_WB) begin
                r_done <= r_legal;
                r_err  <= !r_legal;
                if (r_legal) begin
                    case (r_op)
                        OP_PUSH, OP_DUP: r_sp <= r_sp + (PTR_W+1)'(1);
                        OP_POP:          r_sp <= r_sp - (PTR_W+1)'(1);
                        OP_ADD, OP_SUB, OP_AND: begin
                            r_sp        <= r_sp - (PTR_W+1)'(1);
                            r_zero_flag <= r_res_zero;
                        end
                        OP_CLEAR:        r_sp <= '0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Stack storage, written only at the end of WB for a legal command.
    // NOTE: storage has no reset; sp alone defines which entries are valid,
    // and leaving the array unreset lets it map onto plain register-file cells.
    always_ff @(posedge clk) begin
        if (r_state == S_WB && r_legal) begin
            case (r_op)
                OP_PUSH, OP_DUP:        r_stack[w_push_idx] <= r_result;
                OP_ADD, OP_SUB, OP_AND: r_stack[w_nos_idx]  <= r_result;
                OP_SWAP: begin
                    r_stack[w_top_idx] <= r_stack[w_nos_idx];
                    r_stack[w_nos_idx] <= r_stack[w_top_idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Self-checking bench for stack_alu_sequencer: directed steps plus random
// commands checked against a queue-based stack model and a simple ALU model.
module tb_stack_alu_sequencer;

    localparam logic [2:0] OP_PUSH  = 3'd0;
    localparam logic [2:0] OP_POP   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_DUP   = 3'd5;
    localparam logic [2:0] OP_SWAP  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    logic       clk;
    logic       reset_n;
    logic [1:0] alu_control;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic [7:0] tos;
    logic [3:0] depth;
    logic       empty;
    logic       full;
    logic       zero_flag;

    stack_alu_sequencer_if #(.WIDTH(8)) cmd_if ();

    stack_alu_sequencer #(.WIDTH(8), .PTR_W(3)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd         (cmd_if),
        .alu_control (alu_control),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .tos         (tos),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .zero_flag   (zero_flag)
    );

    // External ALU model.
    always_comb begin
        case (alu_control)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a & alu_b;
            default: alu_out = alu_b;
        endcase
    end
    assign alu_zero = (alu_out == 8'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] model_stk [$];
    logic       model_zf;
    logic [1:0] ex_ctl;
    logic [7:0] ex_a;
    logic [7:0] ex_b;
    logic       last_done;
    logic       last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_tos();
        return (model_stk.size() > 0) ? model_stk[model_stk.size()-1] : 8'd0;
    endfunction

    // Check the status outputs against the model stack.
    task automatic check_status(input string tag);
        check({tag, "_tos"},   32'(tos),   32'(model_tos()));
        check({tag, "_depth"}, 32'(depth), model_stk.size());
        check({tag, "_empty"}, 32'(empty), 32'(model_stk.size() == 0));
        check({tag, "_full"},  32'(full),  32'(model_stk.size() == 8));
        check({tag, "_zf"},    32'(zero_flag), 32'(model_zf));
    endtask

    // Apply the model's effect of one accepted command; returns legality.
    function automatic bit model_apply(input logic [2:0] op, input logic [7:0] data);
        int n;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        n = model_stk.size();
        case (op)
            OP_PUSH: begin
                if (n >= 8) return 1'b0;
                model_stk.push_back(data);
            end
            OP_POP: begin
                if (n < 1) return 1'b0;
                void'(model_stk.pop_back());
            end
            OP_ADD, OP_SUB, OP_AND: begin
                if (n < 2) return 1'b0;
                b = model_stk.pop_back();
                a = model_stk.pop_back();
                r = (op == OP_ADD) ? a + b : (op == OP_SUB) ? a - b : a & b;
                model_stk.push_back(r);
                model_zf = (r == 8'd0);
            end
            OP_DUP: begin
                if (n < 1 || n >= 8) return 1'b0;
                model_stk.push_back(model_stk[n-1]);
            end
            OP_SWAP: begin
                if (n < 2) return 1'b0;
                b = model_stk.pop_back();
                a = model_stk.pop_back();
                model_stk.push_back(b);
                model_stk.push_back(a);
            end
            default: model_stk.delete();
        endcase
        return 1'b1;
    endfunction

    // Issue one command from a negedge and follow it to its done/err cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [7:0] data);
        int         n;
        int         waited;
        bit         legal;
        bit         chk_ab;
        logic [7:0] top;
        logic [7:0] nos;
        logic [1:0] e_ctl;
        logic [7:0] e_a;
        logic [7:0] e_b;
        waited = 0;
        while (cmd_if.cmd_ready !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", 32'(cmd_if.cmd_ready), 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        @(posedge clk);
        @(negedge clk);
        // EXEC cycle: scramble the bus to confirm the command was latched.
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'($urandom);
        cmd_if.cmd_data  = 8'($urandom);
        n   = model_stk.size();
        top = (n > 0) ? model_stk[n-1] : 8'd0;
        nos = (n > 1) ? model_stk[n-2] : 8'd0;
        e_ctl = 2'd0; e_a = 8'd0; e_b = 8'd0; chk_ab = 1'b1;
        case (op)
            OP_PUSH: begin e_ctl = 2'd3; e_b = data; end
            OP_DUP:  begin e_ctl = 2'd3; e_b = top; end
            OP_ADD:  begin e_ctl = 2'd0; e_a = nos; e_b = top; chk_ab = (n >= 2); end
            OP_SUB:  begin e_ctl = 2'd1; e_a = nos; e_b = top; chk_ab = (n >= 2); end
            OP_AND:  begin e_ctl = 2'd2; e_a = nos; e_b = top; chk_ab = (n >= 2); end
            default: ;
        endcase
        ex_ctl = alu_control;
        ex_a   = alu_a;
        ex_b   = alu_b;
        check("exec_alu_control", 32'(alu_control), 32'(e_ctl));
        if (chk_ab) begin
            check("exec_alu_a", 32'(alu_a), 32'(e_a));
            check("exec_alu_b", 32'(alu_b), 32'(e_b));
        end
        check("exec_cmd_ready", 32'(cmd_if.cmd_ready), 0);
        check("exec_no_pulse", 32'({cmd_if.done, cmd_if.err}), 0);
        @(negedge clk);
        check("wb_no_pulse", 32'({cmd_if.done, cmd_if.err}), 0);
        check("wb_alu_idle", 32'({alu_control, alu_a, alu_b}), 0);
        legal = model_apply(op, data);
        @(negedge clk);
        // Done cycle: third cycle counting the acceptance cycle.
        check("done_pulse", 32'(cmd_if.done), 32'(legal));
        check("err_pulse",  32'(cmd_if.err),  32'(!legal));
        check("done_cycle_ready", 32'(cmd_if.cmd_ready), 1);
        check_status("post_cmd");
        last_done = cmd_if.done;
        last_err  = cmd_if.err;
    endtask

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b_vals [4];
        int         acc_cyc [4];
        int         accepted;
        logic       will_accept;
        logic [2:0] rop;

        model_zf         = 1'b0;
        reset_n          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 3'd0;
        cmd_if.cmd_data  = 8'd0;
        repeat (3) @(negedge clk);
        // Reset state while reset is held.
        check("rst_ready", 32'(cmd_if.cmd_ready), 1);
        check("rst_pulses", 32'({cmd_if.done, cmd_if.err}), 0);
        check("rst_alu", 32'({alu_control, alu_a, alu_b}), 0);
        check("rst_depth", 32'(depth), 0);
        check("rst_tos", 32'(tos), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_zf", 32'(zero_flag), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // PUSH 5, PUSH 3, SUB -> 2, ALU sees sub 5,3.
        run_cmd(OP_PUSH, 8'd5);
        check("push5_done", 32'(last_done), 1);
        run_cmd(OP_PUSH, 8'd3);
        run_cmd(OP_SUB, 8'hAA);
        check("sub_exec_ctl", 32'(ex_ctl), 1);
        check("sub_exec_a", 32'(ex_a), 5);
        check("sub_exec_b", 32'(ex_b), 3);
        check("sub_tos", 32'(tos), 2);
        check("sub_depth", 32'(depth), 1);
        check("sub_zf", 32'(zero_flag), 0);

        // AND to zero sets zero_flag, ADD to one clears it.
        run_cmd(OP_CLEAR, 8'd0);
        run_cmd(OP_PUSH, 8'h0F);
        run_cmd(OP_PUSH, 8'hF0);
        run_cmd(OP_AND, 8'd0);
        check("and_tos", 32'(tos), 0);
        check("and_zf", 32'(zero_flag), 1);
        run_cmd(OP_PUSH, 8'd1);
        check("push_keeps_zf", 32'(zero_flag), 1);
        run_cmd(OP_ADD, 8'd0);
        check("add_tos", 32'(tos), 1);
        check("add_zf", 32'(zero_flag), 0);

        // Underflow on empty stack.
        run_cmd(OP_CLEAR, 8'd0);
        run_cmd(OP_ADD, 8'd0);
        check("empty_add_err", 32'(last_err), 1);
        check("empty_add_depth", 32'(depth), 0);
        run_cmd(OP_POP, 8'd0);
        check("empty_pop_err", 32'(last_err), 1);
        run_cmd(OP_CLEAR, 8'd0);
        check("empty_clear_done", 32'(last_done), 1);

        // Fill to full, overflow, DUP when full, then POP.
        for (int i = 1; i <= 8; i++) run_cmd(OP_PUSH, 8'(i));
        check("fill_full", 32'(full), 1);
        check("fill_depth", 32'(depth), 8);
        run_cmd(OP_PUSH, 8'd9);
        check("overflow_err", 32'(last_err), 1);
        check("overflow_tos", 32'(tos), 8);
        run_cmd(OP_DUP, 8'd0);
        check("full_dup_err", 32'(last_err), 1);
        run_cmd(OP_POP, 8'd0);
        check("pop_tos", 32'(tos), 7);
        check("pop_full", 32'(full), 0);

        // SWAP then SUB, and SUB wrap-around.
        run_cmd(OP_CLEAR, 8'd0);
        run_cmd(OP_PUSH, 8'h01);
        run_cmd(OP_PUSH, 8'h02);
        run_cmd(OP_SWAP, 8'd0);
        check("swap_tos", 32'(tos), 1);
        run_cmd(OP_SUB, 8'd0);
        check("swap_sub_tos", 32'(tos), 1);
        run_cmd(OP_PUSH, 8'd3);
        run_cmd(OP_SUB, 8'd0);
        check("sub_wrap_tos", 32'(tos), 8'hFE);
        run_cmd(OP_DUP, 8'd0);
        check("dup_tos", 32'(tos), 8'hFE);

        // Back-to-back: cmd_valid held high across four PUSHes.
        run_cmd(OP_CLEAR, 8'd0);
        b2b_vals[0] = 8'h11; b2b_vals[1] = 8'h22; b2b_vals[2] = 8'h33; b2b_vals[3] = 8'h44;
        accepted = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_PUSH;
        cmd_if.cmd_data  = b2b_vals[0];
        for (int c = 0; c < 40 && accepted < 4; c++) begin
            will_accept = cmd_if.cmd_ready;
            @(posedge clk);
            @(negedge clk);
            if (will_accept) begin
                acc_cyc[accepted] = c;
                void'(model_apply(OP_PUSH, b2b_vals[accepted]));
                accepted++;
                if (accepted < 4) cmd_if.cmd_data = b2b_vals[accepted];
                else cmd_if.cmd_valid = 1'b0;
            end
        end
        check("b2b_accepted", accepted, 4);
        for (int i = 1; i < 4; i++) check("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 3);
        repeat (2) @(negedge clk);
        check("b2b_last_done", 32'(cmd_if.done), 1);
        check_status("b2b");

        // Randomized commands against the model.
        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == OP_CLEAR && $urandom_range(0, 3) != 0) rop = OP_PUSH;
            run_cmd(rop, 8'($urandom));
        end

        // Reset during EXEC aborts the command.
        run_cmd(OP_CLEAR, 8'd0);
        run_cmd(OP_PUSH, 8'h55);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_PUSH;
        cmd_if.cmd_data  = 8'h66;
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        check("abort_in_exec", 32'(alu_control), 3);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_stk.delete();
        model_zf = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(cmd_if.cmd_ready), 1);
        check("abort_pulses", 32'({cmd_if.done, cmd_if.err}), 0);
        check_status("abort");
        @(negedge clk);
        check("abort_no_late_pulse", 32'({cmd_if.done, cmd_if.err}), 0);
        run_cmd(OP_PUSH, 8'h77);
        check("after_abort_tos", 32'(tos), 8'h77);
        check("after_abort_depth", 32'(depth), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/stack_alu_sequencer.md
Name: stack_alu_sequencer

Overview:
Sequences the 8-bit ALU in the stack processor as a small evaluation-stack engine. It accepts one stack command at a time over a valid/ready handshake and holds a DEPTH-entry operand stack. It drives the ALU's control, a and b inputs, then writes the ALU result back onto the stack. It reports top-of-stack, depth, zero flag and error status.

Parameters:
WIDTH, 8, data and ALU operand width
PTR_W, 3, stack pointer width; DEPTH = 2**PTR_W entries (8)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  3  0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 AND, 5 DUP, 6 SWAP, 7 CLEAR
cmd_data  input  WIDTH  immediate for PUSH, ignored otherwise
alu_control  output  2  to ALU: 0 add, 1 sub, 2 and, 3 pass b
alu_a  output  WIDTH  to ALU operand a
alu_b  output  WIDTH  to ALU operand b
alu_out  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
tos  output  WIDTH  top-of-stack value, 0 when empty
depth  output  PTR_W+1  entries in use, 0..DEPTH
empty  output  1  depth == 0
full  output  1  depth == DEPTH
zero_flag  output  1  registered zero result of last successful ADD/SUB/AND
done  output  1  one-cycle pulse: command completed successfully
err  output  1  one-cycle pulse: command rejected, stack unchanged

Behaviour:
- Reset (async, reset_n=0): state IDLE, sp=0, zero_flag=0, done=0, err=0, alu_control=0, alu_a=0, alu_b=0. Stack storage is not cleared. Reset mid-command aborts it with no write.
- FSM is IDLE -> EXEC -> WB -> IDLE. cmd_ready = (state==IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready. cmd_op and cmd_data are latched at acceptance.
- EXEC (1 cycle): drive ALU. alu_out is captured into a result register at the end of EXEC.
  - PUSH: control=3, a=0, b=cmd_data.
  - DUP: control=3, a=0, b=TOS.
  - ADD/SUB/AND: control=0/1/2, a=NOS (entry sp-2), b=TOS (entry sp-1).
  - POP/SWAP/CLEAR: control=0, a=b=0.
  - Outside EXEC: control=0, a=b=0.
  - Legality is checked in EXEC:
    - PUSH/DUP are illegal if full; DUP is also illegal if empty.
    - POP is illegal if depth<1.
    - ADD/SUB/AND/SWAP are illegal if depth<2.
- WB (1 cycle), legal command; the update occurs at the end of WB:
  - PUSH/DUP: stack[sp]=result, sp+1.
  - POP: sp-1.
  - ADD/SUB/AND: stack[sp-2]=result, sp-1. zero_flag=alu_zero value captured in EXEC.
  - SWAP: exchange entries sp-1 and sp-2.
  - CLEAR: sp=0; always legal, including when empty.
- WB, illegal command: no stack, sp or zero_flag change.
- done or err is registered high for exactly the one cycle after WB. That cycle is IDLE, so a new command can be accepted in it.
- Latency: acceptance edge -> done/err visible 3 cycles later. Peak throughput is one command per 3 cycles.
- SUB computes NOS - TOS, modulo 2**WIDTH (wraps). ADD also wraps; no carry is kept.
- tos, depth, empty and full are combinational from sp and storage. They reflect the post-WB state in the done cycle.
- zero_flag is unaffected by PUSH/POP/DUP/SWAP/CLEAR.
- cmd_valid without cmd_ready: the command is held by the source, and nothing is sampled.

Test Plan:
- Reset, then PUSH 5, PUSH 3, SUB -> done pulses each; tos=2, depth=1, zero_flag=0. During SUB EXEC: alu_control=1, alu_a=5, alu_b=3.
- PUSH 0x0F, PUSH 0xF0, AND -> tos=0x00, zero_flag=1. Then PUSH 1, ADD -> tos=1, zero_flag=0.
- Empty stack: ADD -> err pulse 3 cycles after acceptance, depth stays 0. POP -> err. CLEAR -> done.
- PUSH 1..8 -> full=1, depth=8. PUSH 9 -> err, tos=8. DUP -> err. POP -> tos=7, full=0.
- PUSH 0x01, PUSH 0x02, SWAP -> tos=0x01. SUB -> tos=0x01 (2-1). PUSH 3, SUB -> tos=0xFE (wrap).
- Hold cmd_valid high with back-to-back ops: accept only when cmd_ready=1, one command per 3 cycles. Assert reset_n=0 during EXEC -> depth=0, done/err=0, cmd_ready=1 after release.
